// File: rtl/control_unit_if.sv
// +-----------------------------------------------------------------------+
// | control_unit_if                                                       |
// | Unified memory bus between the control unit (master) and memory.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

interface control_unit_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  addr_sel,
    output mem_ready
  );
endinterface

`default_nettype wire

// File: rtl/control_unit.sv
// +-----------------------------------------------------------------------+
// | control_unit                                                          |
// | Multicycle RV64I control FSM with memory handshake and bus timeout.   |
// | Optional: UC_ILLEGAL_TRAP_EN traps illegal opcodes instead of NOP.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module control_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [6:0]        opcode,
  control_unit_if.master    bus,
  output logic              load_ir,
  output logic              load_pc,
  output logic              pc_next_sel,
  output logic              pc_adder_sel,
  output logic              WE_RF,
  output logic [1:0]        RF_din_sel,
  output logic              ULA_din2_sel,
  output logic              illegal,
  output logic              bus_error,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_TRAP   = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    CL_ALU     = 4'd0,
    CL_ALUI    = 4'd1,
    CL_LOAD    = 4'd2,
    CL_STORE   = 4'd3,
    CL_BRANCH  = 4'd4,
    CL_JAL     = 4'd5,
    CL_JALR    = 4'd6,
    CL_LUI     = 4'd7,
    CL_AUIPC   = 4'd8,
    CL_ILLEGAL = 4'd9
  } class_t;

  localparam logic [7:0] c_timeout    = TIMEOUT[7:0];
  localparam bit         c_timeout_en = (TIMEOUT != 0);

  state_t     r_state;
  state_t     w_next;
  class_t     r_class;
  class_t     w_dec_class;
  logic [7:0] r_cnt;
  logic       r_bus_error;
  logic       w_waiting;
  logic       w_bus_trap;

  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_addr_sel;

  function automatic class_t decode_class(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0111011: decode_class = CL_ALU;
      7'b0010011, 7'b0011011: decode_class = CL_ALUI;
      7'b0000011:             decode_class = CL_LOAD;
      7'b0100011:             decode_class = CL_STORE;
      7'b1100011:             decode_class = CL_BRANCH;
      7'b1101111:             decode_class = CL_JAL;
      7'b1100111:             decode_class = CL_JALR;
      7'b0110111:             decode_class = CL_LUI;
      7'b0010111:             decode_class = CL_AUIPC;
      default:                decode_class = CL_ILLEGAL;
    endcase
  endfunction

  assign w_dec_class = decode_class(opcode);

  // A bus access that is still outstanding this cycle; mem_ready outside
  // FETCH/MEM is never looked at.
  assign w_waiting  = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !bus.mem_ready;
  assign w_bus_trap = c_timeout_en && w_waiting && (r_cnt == c_timeout);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH: begin
        if (bus.mem_ready)   w_next = ST_DECODE;
        else if (w_bus_trap) w_next = ST_TRAP;
      end
      ST_DECODE: begin
        case (w_dec_class)
          CL_LOAD, CL_STORE: w_next = ST_MEM;
          CL_ILLEGAL: begin
`ifdef UC_ILLEGAL_TRAP_EN
            w_next = ST_TRAP;
`else
            w_next = ST_EXEC;
`endif
          end
          default:           w_next = ST_EXEC;
        endcase
      end
      ST_EXEC:  w_next = ST_FETCH;
      ST_MEM: begin
        if (bus.mem_ready)   w_next = ST_FETCH;
        else if (w_bus_trap) w_next = ST_TRAP;
      end
      ST_TRAP:  w_next = ST_TRAP;
      default:  w_next = ST_FETCH;
    endcase
  end

`ifdef UC_ILLEGAL_TRAP_EN
  logic r_illegal;
  logic w_ill_trap;
  assign w_ill_trap = (r_state == ST_DECODE) && (w_dec_class == CL_ILLEGAL);
  assign illegal    = r_illegal;
`else
  assign illegal    = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state     <= ST_FETCH;
      r_class     <= CL_ILLEGAL;
      r_cnt       <= 8'd0;
      r_bus_error <= 1'b0;
`ifdef UC_ILLEGAL_TRAP_EN
      r_illegal   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      // Counter restarts on every state entry, counts only unanswered cycles.
      if (w_next != r_state)
        r_cnt <= 8'd0;
      else if (w_waiting)
        r_cnt <= r_cnt + 8'd1;
      if (r_state == ST_DECODE)
        r_class <= w_dec_class;
      if (w_bus_trap)
        r_bus_error <= 1'b1;
`ifdef UC_ILLEGAL_TRAP_EN
      if (w_ill_trap)
        r_illegal <= 1'b1;
`endif
    end
  end

  always_comb begin
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_addr_sel   = 1'b0;
    load_ir      = 1'b0;
    load_pc      = 1'b0;
    pc_next_sel  = 1'b0;
    pc_adder_sel = 1'b0;
    WE_RF        = 1'b0;
    RF_din_sel   = 2'b00;
    ULA_din2_sel = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_mem_req  = 1'b1;
        w_addr_sel = 1'b1;
        load_ir    = bus.mem_ready;
      end
      ST_EXEC: begin
        load_pc = 1'b1;
        case (r_class)
          CL_ALU: begin
            WE_RF      = 1'b1;
            RF_din_sel = 2'b01;
          end
          CL_ALUI, CL_LUI: begin
            WE_RF        = 1'b1;
            RF_din_sel   = 2'b01;
            ULA_din2_sel = 1'b1;
          end
          CL_AUIPC: begin
            WE_RF      = 1'b1;
            RF_din_sel = 2'b11;
          end
          CL_BRANCH: pc_next_sel = 1'b1;
          CL_JAL: begin
            WE_RF       = 1'b1;
            RF_din_sel  = 2'b10;
            pc_next_sel = 1'b1;
          end
          CL_JALR: begin
            WE_RF        = 1'b1;
            RF_din_sel   = 2'b10;
            pc_next_sel  = 1'b1;
            pc_adder_sel = 1'b1;
          end
          default: ;  // illegal opcode executes as a NOP
        endcase
      end
      ST_MEM: begin
        w_mem_req    = 1'b1;
        ULA_din2_sel = 1'b1;
        w_mem_we     = (r_class == CL_STORE);
        if (bus.mem_ready) begin
          load_pc = 1'b1;
          WE_RF   = (r_class == CL_LOAD);
        end
      end
      default: ;
    endcase
    // Reset must not let a strobe escape, even before the clock edge.
    if (reset) begin
      w_mem_req = 1'b0;
      w_mem_we  = 1'b0;
      load_ir   = 1'b0;
      load_pc   = 1'b0;
      WE_RF     = 1'b0;
    end
  end

  assign bus.mem_req  = w_mem_req;
  assign bus.mem_we   = w_mem_we;
  assign bus.addr_sel = w_addr_sel;
  assign bus_error    = r_bus_error;
  assign state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle vector table through a
// scoreboard queue, plus hand-written timeout and retirement sequences.
`default_nettype none

module tb_control_unit;

  logic       CLK;
  logic       reset;
  logic [6:0] opcode;
  logic       load_ir, load_pc, pc_next_sel, pc_adder_sel, WE_RF;
  logic [1:0] RF_din_sel;
  logic       ULA_din2_sel, illegal, bus_error;
  logic [2:0] state;

  control_unit_if bus();

  control_unit #(.TIMEOUT(4)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .opcode       (opcode),
    .bus          (bus),
    .load_ir      (load_ir),
    .load_pc      (load_pc),
    .pc_next_sel  (pc_next_sel),
    .pc_adder_sel (pc_adder_sel),
    .WE_RF        (WE_RF),
    .RF_din_sel   (RF_din_sel),
    .ULA_din2_sel (ULA_din2_sel),
    .illegal      (illegal),
    .bus_error    (bus_error),
    .state        (state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_ALUW  = 7'b0111011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;
  localparam logic [6:0] OP_ALUIW = 7'b0011011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_ILL   = 7'b1111111;

`ifdef UC_ILLEGAL_TRAP_EN
  localparam logic ILL_TRAPS = 1'b1;
`else
  localparam logic ILL_TRAPS = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        rdy;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] sb[$];
  int          total  = 0;
  int          passed = 0;

  // {state, mem_req, mem_we, addr_sel, load_ir, load_pc, pc_next_sel,
  //  pc_adder_sel, WE_RF, RF_din_sel, ULA_din2_sel, illegal, bus_error}
  function automatic logic [15:0] ex(input logic [2:0] st, input logic req, we, asel,
                                     lir, lpc, pns, pas, werf, input logic [1:0] rfs,
                                     input logic ula, ill, be);
    ex = {st, req, we, asel, lir, lpc, pns, pas, werf, rfs, ula, ill, be};
  endfunction

  function automatic logic [15:0] f_fetch(input logic rdy);
    f_fetch = ex(3'd0, 1'b1, 1'b0, 1'b1, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [15:0] f_decode();
    f_decode = ex(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [15:0] sample();
    sample = {state, bus.mem_req, bus.mem_we, bus.addr_sel, load_ir, load_pc, pc_next_sel,
              pc_adder_sel, WE_RF, RF_din_sel, ULA_din2_sel, illegal, bus_error};
  endfunction

  task automatic add(input logic rst, input logic [6:0] op, input logic rdy, input logic [15:0] e);
    vecs.push_back('{rst: rst, op: op, rdy: rdy, exp: e});
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  // A normal one-cycle EXEC instruction with zero-wait fetch.
  task automatic add_exec(input logic [6:0] op, input logic [15:0] e);
    add(1'b0, op, 1'b1, f_fetch(1'b1));
    add(1'b0, op, 1'b0, f_decode());
    add(1'b0, op, 1'b0, e);
  endtask

  task automatic build_table();
    // Reset held in FETCH: strobes forced low, address select still PC
    add(1'b1, OP_ALU, 1'b1, ex(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    add_exec(OP_ALU,   ex(2, 0, 0, 0, 0, 1, 0, 0, 1, 2'b01, 0, 0, 0));
    // LOAD with two wait cycles in MEM
    add(1'b0, OP_LOAD, 1'b1, f_fetch(1'b1));
    add(1'b0, OP_LOAD, 1'b1, f_decode());
    add(1'b0, OP_LOAD, 1'b0, ex(3, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0));
    add(1'b0, OP_LOAD, 1'b0, ex(3, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0));
    add(1'b0, OP_LOAD, 1'b1, ex(3, 1, 0, 0, 0, 1, 0, 0, 1, 2'b00, 1, 0, 0));
    // STORE with one fetch wait and one MEM wait
    add(1'b0, OP_STORE, 1'b0, f_fetch(1'b0));
    add(1'b0, OP_STORE, 1'b1, f_fetch(1'b1));
    add(1'b0, OP_STORE, 1'b0, f_decode());
    add(1'b0, OP_STORE, 1'b0, ex(3, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0));
    add(1'b0, OP_STORE, 1'b1, ex(3, 1, 1, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0, 0));
    add_exec(OP_JALR,  ex(2, 0, 0, 0, 0, 1, 1, 1, 1, 2'b10, 0, 0, 0));
    add_exec(OP_JAL,   ex(2, 0, 0, 0, 0, 1, 1, 0, 1, 2'b10, 0, 0, 0));
    add_exec(OP_BR,    ex(2, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0));
    add_exec(OP_AUIPC, ex(2, 0, 0, 0, 0, 1, 0, 0, 1, 2'b11, 0, 0, 0));
    add_exec(OP_LUI,   ex(2, 0, 0, 0, 0, 1, 0, 0, 1, 2'b01, 1, 0, 0));
    add_exec(OP_ALUI,  ex(2, 0, 0, 0, 0, 1, 0, 0, 1, 2'b01, 1, 0, 0));
    add_exec(OP_ALUIW, ex(2, 0, 0, 0, 0, 1, 0, 0, 1, 2'b01, 1, 0, 0));
    add_exec(OP_ALUW,  ex(2, 0, 0, 0, 0, 1, 0, 0, 1, 2'b01, 0, 0, 0));
    // mem_ready on the very cycle the count reaches the limit wins
    for (int i = 0; i < 4; i++) add(1'b0, OP_ALU, 1'b0, f_fetch(1'b0));
    add(1'b0, OP_ALU, 1'b1, f_fetch(1'b1));
    add(1'b0, OP_ALU, 1'b1, f_decode());
    add(1'b0, OP_ALU, 1'b1, ex(2, 0, 0, 0, 0, 1, 0, 0, 1, 2'b01, 0, 0, 0));
    // Reset while a LOAD completes in MEM: nothing is committed
    add(1'b0, OP_LOAD, 1'b1, f_fetch(1'b1));
    add(1'b0, OP_LOAD, 1'b1, f_decode());
    add(1'b0, OP_LOAD, 1'b0, ex(3, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0));
    add(1'b1, OP_LOAD, 1'b1, ex(3, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0));
    add(1'b0, OP_STORE, 1'b1, f_fetch(1'b1));
    add(1'b0, OP_STORE, 1'b1, f_decode());
    add(1'b1, OP_STORE, 1'b1, ex(3, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0));
    // Illegal opcode
    add(1'b0, OP_ILL, 1'b1, f_fetch(1'b1));
    add(1'b0, OP_ILL, 1'b1, f_decode());
    if (ILL_TRAPS) begin
      add(1'b0, OP_ILL, 1'b1, ex(4, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0));
      add(1'b0, OP_ILL, 1'b1, ex(4, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0));
      add(1'b1, OP_ILL, 1'b1, ex(4, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0));
    end else begin
      add(1'b0, OP_ILL, 1'b1, ex(2, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0));
    end
    // Bus timeout in MEM: five unanswered cycles, then TRAP
    add(1'b0, OP_LOAD, 1'b1, f_fetch(1'b1));
    add(1'b0, OP_LOAD, 1'b1, f_decode());
    for (int i = 0; i < 5; i++)
      add(1'b0, OP_LOAD, 1'b0, ex(3, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0));
    add(1'b0, OP_LOAD, 1'b1, ex(4, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1));
    add(1'b1, OP_LOAD, 1'b0, ex(4, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1));
    add(1'b0, OP_ALU,  1'b1, f_fetch(1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int lpc;
    int dec;
    int idx;
    logic [6:0] stream[8];
    logic [15:0] e;

    reset         = 1'b1;
    opcode        = OP_ALU;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge CLK);

    build_table();
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge CLK); #1;
      reset         = vecs[i].rst;
      opcode        = vecs[i].op;
      bus.mem_ready = vecs[i].rdy;
      sb.push_back(vecs[i].exp);
      @(negedge CLK);
      e = sb.pop_front();
      check($sformatf("vec%0d", i), {16'd0, sample()}, {16'd0, e});
    end

    // FETCH stuck: count FETCH cycles until the trap
    @(posedge CLK); #1; reset = 1'b1; bus.mem_ready = 1'b0;
    @(posedge CLK); #1; reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (state != 3'd0) break;
      cnt++;
      @(posedge CLK); #1;
    end
    check("fetch_timeout_cycles", cnt, 5);
    check("fetch_timeout_state", {29'd0, state}, 4);
    check("fetch_timeout_bus_error", {31'd0, bus_error}, 1);
    check("trap_mem_req", {31'd0, bus.mem_req}, 0);
    @(posedge CLK); #1; reset = 1'b1;
    @(posedge CLK); #1; reset = 1'b0;
    @(negedge CLK);
    check("post_reset_state", {29'd0, state}, 0);
    check("post_reset_flags", {30'd0, illegal, bus_error}, 0);

    // Zero-wait instruction stream: one load_pc per retired instruction
    stream = '{OP_ALU, OP_LOAD, OP_STORE, OP_JAL, OP_BR, OP_LUI, OP_AUIPC, OP_JALR};
    bus.mem_ready = 1'b1;
    lpc = 0; dec = 0; idx = 0;
    for (int c = 0; c < 60 && lpc < 8; c++) begin
      if (state == 3'd0 && idx < 8) begin
        opcode = stream[idx];
        idx++;
      end
      @(negedge CLK);
      if (load_pc) lpc++;
      if (state == 3'd1) dec++;
      @(posedge CLK); #1;
    end
    check("stream_load_pc", lpc, 8);
    check("stream_decodes", dec, 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
